// File: rtl/bitop_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit AND/OR/XOR/NOR unit; BITOP_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins ties).
// Latency: accept on edge T, registered response valid after edge T+1; one operation in flight, 3-cycle minimum issue interval.
// Backpressure: response held stable until rsp_ready; both readys stay low from acceptance until the response handshake.
module bitop_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t             state_q, state_d;
    logic               last_grant_q;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               id_q;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_zero_q;
    logic               rsp_id_q;
    logic [CNT_W-1:0]   done_count_q;

    logic               grant_vld;
    logic               grant;
    logic               accept;
    logic               rsp_load;
    logic               rsp_done;

    function automatic logic [WIDTH-1:0] bitop(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  bitop = a & b;
            OP_OR:   bitop = a | b;
            OP_XOR:  bitop = a ^ b;
            default: bitop = ~(a | b);
        endcase
    endfunction

    // Grant is a pure function of the valids and last_grant so ready never
    // depends on anything the requester sees downstream.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef BITOP_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = rst_n && (state_q == IDLE) && grant_vld && !grant;
    assign req1_ready = rst_n && (state_q == IDLE) && grant_vld &&  grant;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rsp_load = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_load = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d       = grant ? req1_op : req0_op;
        a_d        = grant ? req1_a  : req0_a;
        b_d        = grant ? req1_b  : req0_b;
        rsp_data_d = bitop(op_q, a_q, b_q);
    end

    // Operand latches carry no reset: they are only read in EXEC, which is
    // always preceded by an acceptance that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
            id_q <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant;
            end
            if (rsp_load) begin
                rsp_data_q <= rsp_data_d;
                rsp_zero_q <= (rsp_data_d == '0);
                rsp_id_q   <= id_q;
            end
            if (rsp_done) begin
                done_count_q <= done_count_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_count_q;

endmodule

// File: tb/tb_bitop_arbiter.sv
// Directed self-checking bench for bitop_arbiter (counter built 4 bits wide to reach wrap quickly).
module tb_bitop_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [WIDTH-1:0] rsp_data;
    logic [CNT_W-1:0] done_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bitop_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy),
        .done_count(done_count)
    );

    // Counts falling edges until rsp_valid is seen; -1 when the bound expires.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({rsp_valid, busy, rsp_id, rsp_zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, busy, rsp_id, rsp_zero});
        end
        checks++;
        if (rsp_data !== 32'h0 || done_count !== 4'd0) begin
            errors++; $display("FAIL reset_regs: data=%h cnt=%0d want 0/0", rsp_data, done_count);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie;
        logic       exp_g [4];
        logic       g;
        int         cyc, prev, lat, w;
        logic [WIDTH-1:0] exp_d;
`ifdef BITOP_ARB_FIXED_PRIO_EN
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        req0_op = 2'b00; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F;
        req1_op = 2'b10; req1_a = 32'hAAAA_AAAA; req1_b = 32'hAAAA_AAAA;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        cyc = 0; prev = 0;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!(req0_ready || req1_ready) && w < 10) begin
                @(negedge clk); cyc++; w++;
            end
            checks++;
            if ((req0_ready ^ req1_ready) !== 1'b1) begin
                errors++; $display("FAIL tie_onehot[%0d]: got %b want one ready", k, {req0_ready, req1_ready});
            end
            g = req1_ready;
            checks++;
            if (g !== exp_g[k]) begin
                errors++; $display("FAIL tie_grant[%0d]: got %0d want %0d", k, g, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev !== 3) begin
                    errors++; $display("FAIL tie_interval[%0d]: got %0d want 3", k, cyc - prev);
                end
            end
            prev = cyc;
            wait_rsp(lat);
            if (lat > 0) cyc += lat;
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL tie_latency[%0d]: got %0d want 2", k, lat);
            end
            exp_d = g ? 32'h0000_0000 : 32'h0F0F_0000;
            checks++;
            if (rsp_data !== exp_d || rsp_id !== g || rsp_zero !== g) begin
                errors++; $display("FAIL tie_rsp[%0d]: got %h id%0d z%0d want %h id%0d z%0d",
                                   k, rsp_data, rsp_id, rsp_zero, exp_d, g, g);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done_count !== 4'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL tie_count: cnt=%0d busy=%b want 4/0", done_count, busy);
        end
    endtask

    task automatic test_single_op;
        int lat;
        req0_op = 2'b01; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
        rsp_ready = 1'b1; req0_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        wait_rsp(lat);
        checks++;
        if (lat !== 2 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL single_latency: lat=%0d rdy=%b want 2/0", lat, req0_ready);
        end
        req0_valid = 1'b0;
        checks++;
        if (rsp_data !== 32'h0000_00FF || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL single_rsp: got %h id%0d z%0d want 000000ff id0 z0", rsp_data, rsp_id, rsp_zero);
        end
        @(negedge clk);
        checks++;
        if (done_count !== 4'd5 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_count: cnt=%0d vld=%b want 5/0", done_count, rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        req1_op = 2'b00; req1_a = 32'h1234_5678; req1_b = 32'hFFFF_0000;
        rsp_ready = 1'b0; req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready: got %b want 1", req1_ready);
        end
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL bp_latency: got %0d want 2", lat);
        end
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_0000 || rsp_id !== 1'b1 ||
                {req0_ready, req1_ready} !== 2'b00 || done_count !== 4'd5) begin
                errors++; $display("FAIL bp_hold[%0d]: vld=%b data=%h id=%0d rdy=%b cnt=%0d want 1/12340000/1/00/5",
                                   i, rsp_valid, rsp_data, rsp_id, {req0_ready, req1_ready}, done_count);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 4'd6) begin
            errors++; $display("FAIL bp_release: vld=%b busy=%b cnt=%0d want 0/0/6", rsp_valid, busy, done_count);
        end
    endtask

    task automatic test_operand_change;
        int lat;
        req0_op = 2'b11; req0_a = 32'h0; req0_b = 32'h0;
        rsp_ready = 1'b1; req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL opchg_ready: got %b want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; req0_op = 2'b00;
        req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        wait_rsp(lat);
        checks++;
        if (lat !== 1 || rsp_data !== 32'hFFFF_FFFF || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL opchg_rsp: lat=%0d data=%h z=%0d id=%0d want 1/ffffffff/0/0",
                               lat, rsp_data, rsp_zero, rsp_id);
        end
        @(negedge clk);
        checks++;
        if (done_count !== 4'd7) begin
            errors++; $display("FAIL opchg_count: got %0d want 7", done_count);
        end
    endtask

    task automatic test_reset_in_exec;
        logic seen;
        int   lat;
        req0_op = 2'b10; req0_a = 32'h1; req0_b = 32'h0;
        rsp_ready = 1'b1; req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rexec_inexec: busy=%b vld=%b want 1/0", busy, rsp_valid);
        end
        req0_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_count !== 4'd0) begin
            errors++; $display("FAIL rexec_state: busy=%b vld=%b cnt=%0d want 0/0/0", busy, rsp_valid, done_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rexec_norsp: got rsp_valid seen=%b want 0", seen);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rexec_tie: got %b want 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat);
        @(negedge clk);
    endtask

    task automatic test_counter_wrap;
        int lat;
        apply_reset();
        req1_op = 2'b01; req1_b = 32'h0; rsp_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            req1_a = 32'(i);
            req1_valid = 1'b1;
            @(negedge clk);
            req1_valid = 1'b0;
            wait_rsp(lat);
            @(negedge clk);
            checks++;
            if (done_count !== 4'(i)) begin
                errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, done_count, i % 16);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_tie();
        test_single_op();
        test_backpressure();
        test_operand_change();
        test_reset_in_exec();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
